// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM encoding, register map, status bit positions, baud divider.
// The PARITY state exists only when UART_FIFO_PERIF_PARITY_EN is defined.
package uart_pkg;

  localparam int CLK_DIV_115200 = 234;  // 27 MHz / 115200 baud

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_FIFO_PERIF_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_t;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO; rdata is the head entry whenever empty is low.
// Pushes while full and pops while empty are ignored; fullness is judged before a same-cycle pop.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

endmodule

// File: rtl/uart_fifo_perif.sv
// 6502-bus UART transmitter with TX FIFO; parity bit enabled by UART_FIFO_PERIF_PARITY_EN.
// The CPU read-data port is named dout because "do" is a reserved word in SystemVerilog.
module uart_fifo_perif
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] di,
  output logic [7:0] dout,
  output logic       tx,
  output logic       busy,
  output logic       irq
);
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  tx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             tx_n;
  logic             bit_end;

  logic [1:0]       ctrl;
  logic             ctrl_par_wr;
  logic             overflow;
  logic [7:0]       rdata;

  logic             wr_acc, rd_acc, stat_rd;
  logic             push, pop, full, empty;
  logic [7:0]       fifo_q;
  logic [LVL_W-1:0] level;

`ifdef UART_FIFO_PERIF_PARITY_EN
  function automatic logic parity_bit(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction
  assign ctrl_par_wr = di[1];
`else
  assign ctrl_par_wr = 1'b0;
`endif

  assign wr_acc  = cs & we & ~rst;
  assign rd_acc  = cs & ~we & ~rst;
  assign stat_rd = rd_acc & (addr == ADDR_STATUS);
  assign push    = wr_acc & (addr == ADDR_DATA);

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (di),
    .rdata (fifo_q),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_DATA:   rdata[LVL_W-1:0] = level;
      ADDR_STATUS: begin
        rdata[STAT_OVF]   = overflow;
        rdata[STAT_EMPTY] = empty;
        rdata[STAT_FULL]  = full;
        rdata[STAT_BUSY]  = busy;
      end
      ADDR_CTRL:   rdata[1:0] = ctrl;
      default:     rdata = '0;
    endcase
  end

  // Bus side: control register, sticky overflow, registered read data and irq
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl     <= '0;
      overflow <= 1'b0;
      dout     <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_acc && addr == ADDR_CTRL) ctrl <= {ctrl_par_wr, di[0]};
      overflow <= (push & full) | (overflow & ~stat_rd);
      dout     <= rd_acc ? rdata : 8'h00;
      irq      <= ctrl[0] & empty & ~busy;
    end
  end

  // TX state register; tx and busy are registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      tx      <= tx_n;
      busy    <= (state_n != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_n;
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    pop       = 1'b0;
    tx_n      = 1'b1;
    bit_end   = (cnt == CNT_W'(CLK_DIV - 1));

    if (state != IDLE) cnt_n = bit_end ? '0 : cnt + 1'b1;

    case (state)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        shreg_n = fifo_q;
        cnt_n   = '0;
        state_n = START;
      end
      START: if (bit_end) begin
        bit_idx_n = '0;
        state_n   = DATA;
      end
      DATA: if (bit_end) begin
        // Index holds at 7 after the last data bit; it is cleared in STOP.
        if (bit_idx == 3'd7) begin
`ifdef UART_FIFO_PERIF_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end else begin
          bit_idx_n = bit_idx + 1'b1;
        end
      end
`ifdef UART_FIFO_PERIF_PARITY_EN
      PARITY: if (bit_end) state_n = STOP;
`endif
      STOP: if (bit_end) begin
        bit_idx_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          shreg_n = fifo_q;
          state_n = START;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[bit_idx_n];
`ifdef UART_FIFO_PERIF_PARITY_EN
      PARITY:  tx_n = parity_bit(shreg_n, ctrl[1]);
`endif
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_fifo_perif.sv
// Directed self-checking bench for uart_fifo_perif at CLK_DIV=4, FIFO_DEPTH=16.
// Parity frames are checked when UART_FIFO_PERIF_PARITY_EN is defined.
module tb_uart_fifo_perif;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs;
  logic       we;
  logic [1:0] addr;
  logic [7:0] di;
  logic [7:0] dout;
  logic       tx;
  logic       busy;
  logic       irq;

  int checks = 0;
  int errors = 0;

  uart_fifo_perif #(
    .CLK_DIV    (DIV),
    .FIFO_DEPTH (16)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .cs   (cs),
    .we   (we),
    .addr (addr),
    .di   (di),
    .dout (dout),
    .tx   (tx),
    .busy (busy),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; di = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    cs = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    d = dout;
    cs = 1'b0;
  endtask

  task automatic capture(input int n, output logic [127:0] txv, output int bcnt);
    txv = '0;
    bcnt = 0;
    for (int i = 0; i < n; i++) begin
      txv[i] = tx;
      bcnt = bcnt + int'(busy);
      @(negedge clk);
    end
  endtask

  // Each frame slot (start/data/parity/stop) lasts DIV cycles on the line.
  function automatic logic [127:0] stretch(input logic [31:0] slots, input int nslots);
    logic [127:0] r = '0;
    for (int i = 0; i < nslots * DIV; i++) r[i] = slots[i / DIV];
    return r;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]   rd;
    logic [127:0] txv;
    int           bcnt;
    int           cyc;

    rst = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; di = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_dout", dout, 8'h00);
    rst = 1'b0;
    bus_read(2'd1, rd); chk("rst_status", rd, 8'h04);
    bus_read(2'd0, rd); chk("rst_level", rd, 8'h00);
    bus_read(2'd2, rd); chk("rst_ctrl", rd, 8'h00);
    chk("dout_clear", dout, 8'h00);
    @(negedge clk);
    chk("dout_after_idle", dout, 8'h00);

    // Single 0x55 frame: start two cycles after the write cycle
    bus_write(2'd0, 8'h55);
    chk("start_not_early", tx, 1'b1);
    @(negedge clk);
    capture(40, txv, bcnt);
    chk("frame_55", txv, stretch({22'b0, 1'b1, 8'h55, 1'b0}, 10));
    chk("busy_55", bcnt, 40);
    chk("idle_busy_55", busy, 1'b0);
    chk("idle_tx_55", tx, 1'b1);

    // Back-to-back frames with no idle gap
    bus_write(2'd0, 8'h00);
    bus_write(2'd0, 8'hFF);
    capture(80, txv, bcnt);
    chk("frames_00_ff", txv, stretch({12'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0}, 20));
    chk("busy_00_ff", bcnt, 80);
    chk("idle_busy_00_ff", busy, 1'b0);

    // Overflow: 18 writes, one popped, 16 stored, last dropped
    for (int i = 0; i < 18; i++) bus_write(2'd0, 8'(i));
    bus_read(2'd1, rd); chk("ovf_status", rd, 8'h0B);
    bus_read(2'd1, rd); chk("ovf_cleared", rd, 8'h03);
    bus_read(2'd0, rd); chk("ovf_level", rd, 8'h10);

    // Reset with writes attempted during reset
    rst = 1'b1;
    bus_write(2'd2, 8'h01);
    bus_write(2'd0, 8'h12);
    chk("rst_mid_tx", tx, 1'b1);
    chk("rst_mid_busy", busy, 1'b0);
    rst = 1'b0;
    bus_read(2'd1, rd); chk("post_rst_status", rd, 8'h04);
    bus_read(2'd0, rd); chk("post_rst_level", rd, 8'h00);
    bus_read(2'd2, rd); chk("rst_write_ignored", rd, 8'h00);

    // Reset during DATA bit 3 of 0xA5 (bit value 0), with 0x3C queued behind it
    bus_write(2'd0, 8'hA5);
    bus_write(2'd0, 8'h3C);
    repeat (17) @(negedge clk);
    chk("a5_bit3", tx, 1'b0);
    chk("a5_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", busy, 1'b0);
    rst = 1'b0;
    bus_read(2'd1, rd); chk("abort_status", rd, 8'h04);
    bus_read(2'd0, rd); chk("abort_level", rd, 8'h00);
    repeat (5) @(negedge clk);
    chk("abort_stays_idle", tx, 1'b1);

    // Transmit-complete interrupt
    bus_write(2'd2, 8'h01);
    bus_read(2'd2, rd); chk("ctrl_irq_en", rd, 8'h01);
    chk("irq_idle", irq, 1'b1);
    bus_write(2'd0, 8'h41);
    chk("irq_hold_write", irq, 1'b1);
    @(negedge clk);
    chk("irq_drop", irq, 1'b0);
    cyc = 0;
    while (busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("busy_41", cyc, 40);
    chk("irq_at_busy_fall", irq, 1'b0);
    @(negedge clk);
    chk("irq_rise", irq, 1'b1);

    // Reserved address
    bus_write(2'd3, 8'hFF);
    bus_read(2'd3, rd); chk("rsvd_read", rd, 8'h00);

`ifdef UART_FIFO_PERIF_PARITY_EN
    bus_write(2'd2, 8'h00);
    bus_write(2'd0, 8'h07);
    @(negedge clk);
    capture(44, txv, bcnt);
    chk("even_par_07", txv, stretch({21'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11));
    chk("busy_even", bcnt, 44);
    bus_write(2'd2, 8'h02);
    bus_read(2'd2, rd); chk("ctrl_odd", rd, 8'h02);
    bus_write(2'd0, 8'h07);
    @(negedge clk);
    capture(44, txv, bcnt);
    chk("odd_par_07", txv, stretch({21'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11));
    chk("busy_odd", bcnt, 44);
`else
    bus_write(2'd2, 8'h03);
    bus_read(2'd2, rd); chk("ctrl_no_parity", rd, 8'h01);
    bus_write(2'd0, 8'h07);
    @(negedge clk);
    capture(40, txv, bcnt);
    chk("frame_07", txv, stretch({22'b0, 1'b1, 8'h07, 1'b0}, 10));
    chk("busy_07", bcnt, 40);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_fifo_perif.md
UART_FIFO_PERIF -- requirements
Module: uart_fifo_perif

Interface
REQ-001 SHALL have parameter CLK_DIV, default 234, meaning clk cycles per bit (27 MHz / 115200 baud); legal values are 2 and above.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning TX FIFO entries; legal values are powers of 2 from 2 to 128.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port cs, input, 1 bit: chip select from the 6502 address decoder.
REQ-006 SHALL have port we, input, 1 bit: 1 = CPU write, 0 = CPU read.
REQ-007 SHALL have port addr, input, 2 bits: register select.
REQ-008 SHALL have port di, input, 8 bits: CPU write data.
REQ-009 SHALL have port do, output, 8 bits: registered CPU read data.
REQ-010 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-011 SHALL have port busy, output, 1 bit: high while a frame is on the line.
REQ-012 SHALL have port irq, output, 1 bit: transmit-complete interrupt, active high.

Function
REQ-013 SHALL decode a bus access as cs=1 for exactly one clk cycle; cs held longer SHALL act as repeated accesses.
REQ-014 SHALL map registers as follows:
- addr 0: write pushes di into the FIFO; read returns the FIFO level.
- addr 1: read returns status {4'b0, overflow, empty, full, busy}.
- addr 2: control register, read/write; bit0 = irq_en, bit1 = odd parity; all other bits read 0.
- addr 3: reserved; reads 0, writes are ignored.
REQ-015 SHALL update do on the cycle after a read (cs=1, we=0), and SHALL drive do to 0 on the cycle after any non-read cycle.
REQ-016 SHALL drop a push to a full FIFO, leave the FIFO unchanged, and set overflow; fullness is evaluated before that cycle's pop.
REQ-017 SHALL clear overflow on a status read; if an overflow event occurs in the same cycle as that read, overflow SHALL be set.
REQ-018 SHALL implement the TX FSM with states IDLE, START, DATA, PARITY and STOP; each bit lasts exactly CLK_DIV cycles.
REQ-019 In IDLE with the FIFO non-empty, the FSM SHALL pop one byte and enter START on the next cycle; tx SHALL go low on the first START cycle.
REQ-020 In DATA, the FSM SHALL send 8 bits LSB first; the bit index SHALL count 0..7 and must not wrap mid-frame.
REQ-021 On the last STOP cycle, if the FIFO is non-empty the FSM SHALL pop and go directly to START (no idle cycle between frames); otherwise it SHALL go to IDLE.
REQ-022 SHALL drive busy high from the first START cycle through the last STOP cycle.
REQ-023 SHALL drive irq = irq_en & empty & ~busy, registered.
REQ-024 A push to an empty FIFO while idle SHALL appear on tx as a start bit exactly 2 cycles after the write cycle.

Reset
REQ-025 SHALL apply the following while rst=1:
- tx=1, busy=0, irq=0, do=0
- FSM in IDLE, bit counter 0
- FIFO empty, overflow=0, control=0
REQ-026 SHALL, when rst is asserted mid-frame, abort the frame, raise tx high on the next edge, and discard FIFO contents.
REQ-027 SHALL ignore bus writes during reset.

Configuration
REQ-028 With macro UART_FIFO_PERIF_PARITY_EN defined, the FSM SHALL send one parity bit between DATA and STOP: even parity, or odd when control bit1=1.
REQ-029 With UART_FIFO_PERIF_PARITY_EN undefined, the PARITY state SHALL be absent, DATA SHALL go directly to STOP, and control bit1 SHALL read 0 and ignore writes.

Structure
REQ-030 SHALL take from shared package uart_pkg: the FSM state encoding, register address constants, status bit indices and the 115200-baud CLK_DIV constant.
REQ-031 SHALL instantiate sub-module uart_sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level) for the TX buffer.

Verification (CLK_DIV=4, FIFO_DEPTH=16)
REQ-032 Write 0x55 to addr 0 -> tx low for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4 cycles; busy high for 40 cycles.
REQ-033 Write 18 bytes back-to-back -> the first byte is popped, 16 are stored and the 18th is dropped; status reads 0x0B, then 0x03 on an immediate second read.
REQ-034 Write 0x00 then 0xFF -> the second start bit immediately follows the first stop bit; busy stays high for 80 contiguous cycles.
REQ-035 Assert rst during DATA bit 3 of 0xA5 -> tx=1 on the next cycle; after release, status reads 0x04 and level reads 0.
REQ-036 Write 0x01 to addr 2, then send 0x41 -> irq rises 1 cycle after busy falls and drops 1 cycle after the next data write.
REQ-037 With the parity macro: 0x07 with even parity -> parity bit 1; 0x07 with odd parity (control 0x02) -> parity bit 0; frame is 44 cycles.
